// File: rtl/aes_encipher_pblock.sv
// aes_encipher_pblock: AES encipher round datapath; NUM_SBOX 32-bit words are substituted per cycle.
// The round keys come from an external key expander that is indexed by round.
module aes_sbox (
  input  logic [31:0] sbox_i,
  output logic [31:0] sbox_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  for (genvar i = 0; i < 4; i++) begin : g_b
    assign sbox_o[8*i +: 8] = SBOX[~{sbox_i[8*i +: 8], 3'b000} -: 8];
  end
endmodule

module aes_encipher_pblock #(
  parameter int NUM_SBOX = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         next,
  input  logic         abort,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic         init_key,
  output logic         next_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         done
);
  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
    $error("aes_encipher_pblock: NUM_SBOX must be 1, 2 or 4");
  end
  // STEP truncates 4 to 0, which is the required mod-4 wrap of sword.
  localparam logic [1:0] STEP = 2'(NUM_SBOX);
  localparam logic [1:0] LAST = 2'(4 - NUM_SBOX);
  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_e;
  state_e       state_q;
  logic [3:0]   round_q;
  logic [1:0]   sword_q;
  logic [127:0] block_q;
  logic         ready_q, done_q;
  logic [3:0]   nr;
  logic [31:0]  w [4];
  logic [31:0]  sout [NUM_SBOX];
  logic [127:0] sub_d, sr, mix_d, fin_d;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = c;
    return {xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3,
            xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3)};
  endfunction

  // Row r of each column is taken from column c+r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    return {s[127:120], s[87:80],   s[47:40],   s[7:0],
            s[95:88],   s[55:48],   s[15:8],    s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],   s[39:32]};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
  endfunction

  assign nr = keylen == 2'd1 ? 4'd14 : keylen == 2'd2 ? 4'd12 : 4'd10;
  assign sr = shift_rows(block_q);
  assign mix_d = mix_columns(sr) ^ round_key;
  assign fin_d = sr ^ round_key;

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_sbox
    aes_sbox u_sbox (.sbox_i(w[sword_q + 2'(i)]), .sbox_o(sout[i]));
  end

  // sword is always group-aligned, so word i of the active group uses S-box i mod NUM_SBOX.
  for (genvar i = 0; i < 4; i++) begin : g_w
    logic [1:0] d;
    assign w[i] = block_q[127-32*i -: 32];
    assign d = 2'(i) - sword_q;
    assign sub_d[127-32*i -: 32] = (3'(d) < 3'(NUM_SBOX)) ? sout[i % NUM_SBOX] : w[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      round_q <= '0;
      sword_q <= '0;
      block_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
        round_q <= '0;
        sword_q <= '0;
        block_q <= '0;
        ready_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (next) begin
            round_q <= '0;
            ready_q <= 1'b0;
            state_q <= INIT;
          end
          INIT: begin
            block_q <= block ^ round_key;
            round_q <= 4'd1;
            sword_q <= '0;
            state_q <= SBOX;
          end
          SBOX: begin
            block_q <= sub_d;
            sword_q <= sword_q + STEP;
            if (sword_q == LAST) state_q <= MAIN;
          end
          MAIN: begin
            round_q <= round_q + 4'd1;
            sword_q <= '0;
            if (round_q < nr) begin
              block_q <= mix_d;
              state_q <= SBOX;
            end else begin
              block_q <= fin_d;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign init_key  = state_q == IDLE && init && !next;
  assign next_key  = state_q == MAIN;
  assign round     = round_q;
  assign new_block = block_q;
  assign ready     = ready_q;
  assign done      = done_q;
endmodule

// File: tb/tb_aes_encipher_pblock.sv
// tb_aes_encipher_pblock: scoreboard bench for NUM_SBOX 1/2/4 against FIPS-197 vectors.
// The bench derives its S-box from GF(2^8) inverses and expands keys itself to feed round_key.
module tb_aes_encipher_pblock;
  typedef struct { logic [127:0] ct; int due; } exp_t;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0, reset_n = 1'b1, init = 1'b0, next = 1'b0, abort = 1'b0;
  logic [1:0]   keylen = 2'd0;
  logic [127:0] block = PT;
  logic [3:0]   rnd [3];
  logic [127:0] rkey [3], nb [3];
  logic         ik [3], nk [3], rdy [3], dn [3];
  logic [127:0] rk [16];
  logic [7:0]   sbox [256];
  exp_t         sb [3][$];
  int cyc = 0, checks = 0, errors = 0, nk_cnt = 0, nk0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (nk[0]) nk_cnt <= nk_cnt + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox;
    logic [7:0] v;
    for (int a = 0; a < 256; a++) begin
      v = 8'h00;
      for (int x = 1; x < 256; x++) if (gmul(8'(a), 8'(x)) == 8'h01) v = 8'(x);
      sbox[a] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  task automatic expand(input logic [1:0] kl, input logic [255:0] key);
    logic [31:0]  w [64];
    logic [31:0]  t;
    logic [255:0] kk;
    logic [7:0]   rc;
    int nkw, nr;
    nkw = kl == 2'd1 ? 8 : kl == 2'd2 ? 6 : 4;
    nr = nkw + 6;
    rc = 8'h01;
    kk = key;
    for (int i = 0; i < 64; i++) begin
      if (i < nkw) begin
        w[i] = kk[255:224];
        kk = kk << 32;
      end else begin
        t = w[i-1];
        if (i % nkw == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nkw == 8 && i % nkw == 4) t = subw(t);
        w[i] = w[i-nkw] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_dut
    exp_t e;
    aes_encipher_pblock #(.NUM_SBOX(1 << k)) u_dut (
      .clk(clk), .reset_n(reset_n), .init(init), .next(next), .abort(abort),
      .keylen(keylen), .round(rnd[k]), .round_key(rkey[k]), .init_key(ik[k]),
      .next_key(nk[k]), .block(block), .new_block(nb[k]), .ready(rdy[k]), .done(dn[k])
    );
    assign rkey[k] = rk[rnd[k]];
    always @(negedge clk) begin
      if (dn[k]) begin
        if (sb[k].size() == 0) chk($sformatf("unexpected_done[%0d]", k), 128'(dn[k]), 128'd0);
        else begin
          e = sb[k].pop_front();
          chk($sformatf("ciphertext[%0d]", k), nb[k], e.ct);
          chk($sformatf("done_cycle[%0d]", k), 128'(cyc), 128'(e.due));
          chk($sformatf("ready_at_done[%0d]", k), 128'(rdy[k]), 128'd1);
        end
      end else if (sb[k].size() != 0 && cyc > sb[k][0].due) begin
        chk($sformatf("done_timeout[%0d]", k), 128'(dn[k]), 128'd1);
        void'(sb[k].pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] kl, input logic [255:0] key, input logic [127:0] ct,
                       input logic with_init);
    int nr;
    expand(kl, key);
    keylen = kl;
    nr = kl == 2'd1 ? 14 : kl == 2'd2 ? 12 : 10;
    @(posedge clk);
    #1;
    next = 1'b1;
    init = with_init;
    for (int k = 0; k < 3; k++) sb[k].push_back('{ct, cyc + 2 + nr * (4 / (1 << k) + 1)});
    #1;
    if (with_init) chk("init_key_with_next", 128'(ik[0]), 128'd0);
    @(posedge clk);
    #1;
    next = 1'b0;
    init = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (sb[0].size() + sb[1].size() + sb[2].size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) chk("drain_timeout", 128'(sb[0].size() + sb[1].size() + sb[2].size()), 128'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic idle_state(input string tag, input logic [127:0] exp_nb);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_ready[%0d]", tag, k), 128'(rdy[k]), 128'd1);
      chk($sformatf("%s_done[%0d]", tag, k), 128'(dn[k]), 128'd0);
      chk($sformatf("%s_round[%0d]", tag, k), 128'(rnd[k]), 128'd0);
      chk($sformatf("%s_block[%0d]", tag, k), nb[k], exp_nb);
    end
  endtask

  initial begin
    build_sbox();
    expand(2'd0, K128);
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle_state("reset", 128'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b1;
    #1;
    chk("init_key_idle", 128'(ik[0]), 128'd1);
    chk("next_key_idle", 128'(nk[0]), 128'd0);
    @(posedge clk);
    #1;
    init = 1'b0;
    chk("ready_after_init", 128'(rdy[0]), 128'd1);
    nk0 = nk_cnt;
    issue(2'd0, K128, CT128, 1'b0);
    drain();
    chk("next_key_count_128", 128'(nk_cnt - nk0), 128'd10);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("hold_block[%0d]", k), nb[k], CT128);
    issue(2'd2, K192, CT192, 1'b0);
    drain();
    nk0 = nk_cnt;
    issue(2'd1, K256, CT256, 1'b0);
    drain();
    chk("next_key_count_256", 128'(nk_cnt - nk0), 128'd14);
    issue(2'd0, K128, CT128, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    abort = 1'b1;
    for (int k = 0; k < 3; k++) sb[k].delete();
    @(posedge clk);
    #1;
    abort = 1'b0;
    idle_state("abort", 128'h0);
    repeat (30) @(posedge clk);
    issue(2'd0, K128, CT128, 1'b0);
    drain();
    issue(2'd0, K128, CT128, 1'b1);
    next = 1'b1;
    init = 1'b1;
    #1;
    chk("init_key_busy", 128'(ik[0]), 128'd0);
    repeat (6) @(posedge clk);
    #1;
    next = 1'b0;
    init = 1'b0;
    drain();
    issue(2'd0, K128, CT128, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) sb[k].delete();
    #1;
    idle_state("midrun_reset", 128'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    idle_state("no_restart", 128'h0);
    issue(2'd0, K128, CT128, 1'b0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/aes_encipher_pblock.md
AES_ENCIPHER_PBLOCK -- requirements
Module: aes_encipher_pblock

Interface
REQ-001 SHALL have parameter NUM_SBOX, default 1, meaning number of 32-bit S-box words substituted per cycle; legal values 1, 2, 4.
REQ-002 SHALL fail elaboration when NUM_SBOX is not 1, 2 or 4.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port init  input  1  request key expansion, honoured in IDLE only.
REQ-006 SHALL have port next  input  1  start encryption of block, honoured in IDLE only.
REQ-007 SHALL have port abort  input  1  cancel operation in progress.
REQ-008 SHALL have port keylen  input  2  key size: 0 = 128, 1 = 256, 2 = 192, 3 = reserved (treated as 128).
REQ-009 SHALL have port round  output  4  current round counter value, indexes round_key.
REQ-010 SHALL have port round_key  input  128  round key for round, valid combinationally in the same cycle.
REQ-011 SHALL have port init_key  output  1  combinational strobe to the key expander.
REQ-012 SHALL have port next_key  output  1  combinational round-advance strobe to the key expander.
REQ-013 SHALL have port block  input  128  plaintext, sampled in INIT.
REQ-014 SHALL have port new_block  output  128  state register / ciphertext.
REQ-015 SHALL have port ready  output  1  high when idle.
REQ-016 SHALL have port done  output  1  one-cycle pulse when ciphertext is valid.

Function
REQ-017 SHALL implement FSM states IDLE, INIT, SBOX, MAIN.
REQ-018 Nr SHALL be 10/12/14 for keylen 0 or 3 / 2 / 1; keylen SHALL be sampled continuously and held stable by the user during operation.
REQ-019 IDLE: next=1 -> round:=0, ready:=0, go to INIT; init_key = init & ~next, so init+next together starts encryption and drops the init.
REQ-020 INIT (1 cycle): new_block := block ^ round_key (round=0); round:=1; sword:=0; -> SBOX.
REQ-021 SBOX SHALL last S = 4/NUM_SBOX cycles; per cycle substitute words sword..sword+NUM_SBOX-1 (w0 = bits 127:96 first) through NUM_SBOX aes_sbox instances, other words held; sword += NUM_SBOX, wrapping mod 4; after the last group -> MAIN.
REQ-022 MAIN (1 cycle): next_key=1; round += 1; sword:=0; if round < Nr then new_block := MixColumns(ShiftRows(state)) ^ round_key, -> SBOX; else new_block := ShiftRows(state) ^ round_key, ready:=1, done:=1 for one cycle, -> IDLE.
REQ-023 ShiftRows/MixColumns SHALL be per FIPS-197; column c = bits [127-32c : 96-32c], byte 0 = MSB of each column.
REQ-024 Latency: next sampled at edge E0 -> ready and done rise at edge E0 + 1 + Nr*(S+1) (AES-128: 51 / 31 / 21 cycles for NUM_SBOX 1 / 2 / 4; AES-256, NUM_SBOX=1: 71).
REQ-025 new_block SHALL hold its value in IDLE until the next INIT overwrites it.
REQ-026 next or init while not in IDLE SHALL be ignored, with no effect on state or outputs.
REQ-027 abort=1 in INIT/SBOX/MAIN -> next edge: IDLE, ready:=1, done stays 0, new_block:=0, round:=0; abort in IDLE SHALL have no effect.
REQ-028 abort SHALL have priority over the MAIN final-round completion in the same cycle (no done pulse).
REQ-029 next_key SHALL be 0 outside MAIN; init_key SHALL be 0 outside IDLE.

Reset
REQ-030 reset_n=0 SHALL asynchronously set: state IDLE, new_block 0, round 0, sword 0, ready 1, done 0.
REQ-031 Reset deassertion mid-operation SHALL require a new next; no partial result is retained.

Verification
REQ-032 AES-128, NUM_SBOX=1, key 000102..0f, block 00112233445566778899aabbccddeeff, round-key model driven by round -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a, done at cycle 51.
REQ-033 Same vector, NUM_SBOX=2 and 4 -> identical ciphertext; done at cycles 31 and 21.
REQ-034 keylen=2, key 00..17 -> dda97ca4864cdfe06eaf70a0ec0d7191; keylen=1, key 00..1f -> 8ea2b7ca516745bfeafc49904b496089 (Nr 12 / 14).
REQ-035 abort at cycle 20 of an AES-128 run -> ready=1 next cycle, new_block=0, no done; a following next yields the correct ciphertext.
REQ-036 next pulsed in SBOX and MAIN, init+next together in IDLE -> mid-run pulses ignored; init_key=0 on the combined cycle; reset_n pulsed mid-run -> outputs match REQ-030 immediately.
